// File: rtl/sdram_arb_pkg.sv
// Shared types and width defaults for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of requester A/B signals and SDRAM controller command/response signals.
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              A_Req;
    logic              B_Req;
    logic              A_Wr;
    logic              B_Wr;
    logic [ADDR_W-1:0] A_Addr;
    logic [ADDR_W-1:0] B_Addr;
    logic [DATA_W-1:0] A_WrData;
    logic [DATA_W-1:0] B_WrData;
    logic              A_Done;
    logic              B_Done;
    logic              A_Err;
    logic              B_Err;
    logic [DATA_W-1:0] RdData_Out;

    logic              WrEN_Sig;
    logic              RdEN_Sig;
    logic [ADDR_W-1:0] BRC_Addr;
    logic [DATA_W-1:0] WrData;
    logic              Done_Sig;
    logic              Busy_Sig;
    logic [DATA_W-1:0] RdData;

    // Arbiter side
    modport slave (
        input  A_Req, B_Req, A_Wr, B_Wr, A_Addr, B_Addr, A_WrData, B_WrData,
        input  Done_Sig, Busy_Sig, RdData,
        output A_Done, B_Done, A_Err, B_Err, RdData_Out,
        output WrEN_Sig, RdEN_Sig, BRC_Addr, WrData
    );

    // Requesters plus SDRAM controller side
    modport master (
        output A_Req, B_Req, A_Wr, B_Wr, A_Addr, B_Addr, A_WrData, B_WrData,
        output Done_Sig, Busy_Sig, RdData,
        input  A_Done, B_Done, A_Err, B_Err, RdData_Out,
        input  WrEN_Sig, RdEN_Sig, BRC_Addr, WrData
    );

endinterface

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker: a tie goes to the port that was not granted last.
module sdram_arb_rr (
    input  logic [1:0] req,
    input  logic       last_b,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | last_b);
    assign grant[1] = req[1] & (~req[0] | ~last_b);

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates two requesters onto one SDRAM controller, one transaction at a time.
// Optional watchdog on stalled transactions: define SDRAM_ARB_WDOG_EN.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WDOG_CYC = 1023
) (
    input logic            CLK,
    input logic            RSTn,
    sdram_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    port_t             winner;
    port_t             last_grant;
    logic [1:0]        grant;
    logic              take;
    logic              timeout;
    logic              err_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    sdram_arb_rr u_rr (
        .req    ({bus.B_Req, bus.A_Req}),
        .last_b (last_grant == PORT_B),
        .grant  (grant)
    );

    assign take = (state == ST_IDLE) && !bus.Busy_Sig && (grant != 2'b00);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT:  if (!bus.Busy_Sig) state_nxt = ST_IDLE;
            ST_IDLE:  if (take) state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.Done_Sig || timeout) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // The winner's command is frozen at the grant edge so the controller sees stable fields
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            winner     <= PORT_A;
            last_grant <= PORT_B;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (take) begin
            if (grant[1]) begin
                winner     <= PORT_B;
                last_grant <= PORT_B;
                wr_q       <= bus.B_Wr;
                addr_q     <= bus.B_Addr;
                wdata_q    <= bus.B_WrData;
            end else begin
                winner     <= PORT_A;
                last_grant <= PORT_A;
                wr_q       <= bus.A_Wr;
                addr_q     <= bus.A_Addr;
                wdata_q    <= bus.A_WrData;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rdata_q <= '0;
        end else if (state == ST_ISSUE && bus.Done_Sig && !wr_q) begin
            rdata_q <= bus.RdData;
        end
    end

`ifdef SDRAM_ARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] wdog_cnt;

    // Controller completion wins over a timeout landing on the same cycle
    assign timeout = (state == ST_ISSUE) && !bus.Done_Sig &&
                     (wdog_cnt == CNT_W'(WDOG_CYC - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else if (take) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == ST_ISSUE) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            err_q    <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    assign bus.WrEN_Sig   = (state == ST_ISSUE) && wr_q;
    assign bus.RdEN_Sig   = (state == ST_ISSUE) && !wr_q;
    assign bus.BRC_Addr   = addr_q;
    assign bus.WrData     = wdata_q;
    assign bus.RdData_Out = rdata_q;
    assign bus.A_Done     = (state == ST_DONE) && (winner == PORT_A);
    assign bus.B_Done     = (state == ST_DONE) && (winner == PORT_B);
    assign bus.A_Err      = bus.A_Done && err_q;
    assign bus.B_Err      = bus.B_Done && err_q;

endmodule
